// File: rtl/ifetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode stage: command
// indices of the one-hot decode, ARM condition codes and fetch states.
package ifetch_decode_pkg;

  localparam int CMD_DP   = 0;
  localparam int CMD_BX   = 1;
  localparam int CMD_B    = 2;
  localparam int CMD_BL   = 3;
  localparam int CMD_LDR0 = 4;
  localparam int CMD_LDR1 = 5;
  localparam int CMD_STR0 = 6;
  localparam int CMD_STR1 = 7;
  localparam int CMD_SWP  = 8;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifd_cond_check.sv
// Combinational ARM condition evaluation; nzcv = {N,Z,C,V}.
// The 1111 encoding is treated as "never".
module ifd_cond_check
  import ifetch_decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  // Condition code lookup against the current flags.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ifetch_decode.sv
// Instruction fetch and decode stage feeding the multi-cycle control FSM.
// Optional macro IFD_ILLEGAL_TRAP_EN adds the 'illegal' output and forces
// cond_fail on undecodable words.
//
// state    | meaning
// ST_IDLE  | no fetch outstanding, IR not valid (after reset or timeout)
// ST_REQ   | imem_req high, waiting for imem_ack or timeout
// ST_VALID | IR holds a freshly fetched word, ir_valid high
module ifetch_decode
  import ifetch_decode_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_ir,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [63:0]       command,
  output logic              rm_imm_s,
  output logic [1:0]        rs_imm_s,
  output logic [2:0]        shift_op,
  output logic [3:0]        alu_op,
  output logic              s_bit,
  output logic              p_bit,
  output logic              u_bit,
  output logic              w_bit,
  output logic [1:0]        v_type,
  input  logic [3:0]        nzcv,
  output logic              cond_fail,
`ifdef IFD_ILLEGAL_TRAP_EN
  output logic              illegal,
`endif
  output logic              bus_err
);

  // Down-counter loaded on each fetch start; terminal count 0 means the
  // last allowed REQ cycle has passed without an ack.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TMO_LOAD =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  fetch_state_t     state, state_nxt;
  logic             write_ir_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             start, timeout_hit;
  logic             load_req, load_ir, abort;

  assign start       = write_ir & ~write_ir_q;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; ack takes priority over timeout, starts in REQ are ignored.
  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    load_ir   = 1'b0;
    abort     = 1'b0;
    case (state)
      ST_IDLE, ST_VALID: begin
        if (start) begin
          state_nxt = ST_REQ;
          load_req  = 1'b1;
        end
      end
      ST_REQ: begin
        if (imem_ack) begin
          state_nxt = ST_VALID;
          load_ir   = 1'b1;
        end else if (timeout_hit) begin
          state_nxt = ST_IDLE;
          abort     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Fetch datapath: address capture, IR load, timeout counter, sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_ir_q <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      bus_err    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      write_ir_q <= write_ir;
      if (load_req) begin
        imem_addr <= pc;
        imem_req  <= 1'b1;
        ir_valid  <= 1'b0;
        tmo_cnt   <= TMO_LOAD;
      end else if (state == ST_REQ && tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - 1'b1;
      end
      if (load_ir) begin
        ir       <= imem_rdata;
        imem_req <= 1'b0;
        ir_valid <= 1'b1;
      end
      if (abort) begin
        imem_req <= 1'b0;
        bus_err  <= 1'b1;
      end
    end
  end

  logic [63:0] cmd_raw;
  logic        is_bx, is_swp, cond_pass;

  assign is_bx  = (ir[27:4] == 24'h12FFF1);
  assign is_swp = (ir[27:23] == 5'b00010) && (ir[21:20] == 2'b00) && (ir[11:4] == 8'h09);

  // One-hot instruction class decode from the IR.
  always_comb begin
    cmd_raw           = '0;
    cmd_raw[CMD_BX]   = is_bx;
    cmd_raw[CMD_SWP]  = is_swp;
    cmd_raw[CMD_DP]   = (ir[27:26] == 2'b00) && !is_bx && !is_swp;
    cmd_raw[CMD_B]    = (ir[27:24] == 4'b1010);
    cmd_raw[CMD_BL]   = (ir[27:24] == 4'b1011);
    cmd_raw[CMD_LDR0] = (ir[27:25] == 3'b010) && ir[20];
    cmd_raw[CMD_LDR1] = (ir[27:25] == 3'b011) && !ir[4] && ir[20];
    cmd_raw[CMD_STR0] = (ir[27:25] == 3'b010) && !ir[20];
    cmd_raw[CMD_STR1] = (ir[27:25] == 3'b011) && !ir[4] && !ir[20];
  end

  ifd_cond_check u_cond (
    .cond (ir[31:28]),
    .nzcv (nzcv),
    .pass (cond_pass)
  );

  assign command  = ir_valid ? cmd_raw : '0;
  assign rm_imm_s = ir[25];
  assign rs_imm_s = {ir[25], ir[4]};
  assign shift_op = {ir[6:5], ir[4]};
  assign alu_op   = ir[24:21];
  assign s_bit    = ir[20];
  assign p_bit    = ir[24];
  assign u_bit    = ir[23];
  assign w_bit    = ir[21];
  assign v_type   = ir[6:5];

`ifdef IFD_ILLEGAL_TRAP_EN
  assign illegal   = ir_valid && (cmd_raw == '0);
  assign cond_fail = ir_valid && (!cond_pass || illegal);
`else
  assign cond_fail = ir_valid && !cond_pass;
`endif

endmodule

// File: tb/tb_ifetch_decode.sv
// Scoreboard bench for ifetch_decode: fetch stimulus pushes hand-computed
// expectations, a monitor pops them on each IR load.
module tb_ifetch_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_ir = 1'b0;
  logic [31:0] pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ir_valid;
  logic [31:0] ir;
  logic [63:0] command;
  logic        rm_imm_s;
  logic [1:0]  rs_imm_s;
  logic [2:0]  shift_op;
  logic [3:0]  alu_op;
  logic        s_bit, p_bit, u_bit, w_bit;
  logic [1:0]  v_type;
  logic [3:0]  nzcv = 4'b0000;
  logic        cond_fail;
  logic        bus_err;
`ifdef IFD_ILLEGAL_TRAP_EN
  logic        illegal;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  always #5 clk = ~clk;

  ifetch_decode dut (
    .clk(clk), .rst(rst), .write_ir(write_ir), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir(ir), .command(command),
    .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .shift_op(shift_op),
    .alu_op(alu_op), .s_bit(s_bit), .p_bit(p_bit), .u_bit(u_bit),
    .w_bit(w_bit), .v_type(v_type), .nzcv(nzcv), .cond_fail(cond_fail),
`ifdef IFD_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    logic [63:0] cmd;
    logic        cf;
    logic [3:0]  alu;
    logic        rm, p, u;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   req_rises = 0;
  int   ir_loads = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: compare against the scoreboard on every rising ir_valid.
  initial begin
    logic vld_prev, req_prev;
    exp_t e;
    vld_prev = 1'b0;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (imem_req && !req_prev) req_rises++;
        if (ir_valid && !vld_prev) begin
          ir_loads++;
          if (sb_q.size() == 0) chk("unexpected_ir_load", 1, 0);
          else begin
            e = sb_q.pop_front();
            chk("imem_addr", imem_addr, e.addr);
            chk("ir", ir, e.word);
            chk("command", command, e.cmd);
            chk("cond_fail", cond_fail, e.cf);
            chk("alu_op", alu_op, e.alu);
            chk("rm_imm_s", rm_imm_s, e.rm);
            chk("p_bit", p_bit, e.p);
            chk("u_bit", u_bit, e.u);
          end
        end
      end
      vld_prev = ir_valid;
      req_prev = imem_req;
    end
  end

  // One fetch: rising write_ir, ack after 'delay' REQ cycles, write_ir held 'hold' extra cycles.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] w, input int delay,
                          input int hold, input exp_t e);
    @(negedge clk);
    pc = a;
    write_ir = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    chk("req_asserted", imem_req, 1);
    pc = a ^ 32'hFFFF_0000;
    repeat (delay) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    repeat (hold) @(negedge clk);
    write_ir = 1'b0;
    @(negedge clk);
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] w, input logic [63:0] cmd,
                              input logic cf, input logic [3:0] alu, input logic rm,
                              input logic p, input logic u);
    exp_t e;
    e.addr = a; e.word = w; e.cmd = cmd; e.cf = cf; e.alu = alu; e.rm = rm; e.p = p; e.u = u;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, l0, cnt;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_command", command, 0);
    chk("rst_cond_fail", cond_fail, 0);
    rst = 1'b0;
    @(negedge clk);

    // MOV-immediate DP, ack on the second REQ cycle
    nzcv = 4'b0000;
    do_fetch(32'h100, 32'hE3A01005, 1, 0, mk(32'h100, 32'hE3A01005, 64'h1, 0, 4'b1101, 1, 1, 1));

    // write_ir held high for five cycles: one request, one IR load
    r0 = req_rises; l0 = ir_loads;
    do_fetch(32'h104, 32'hE5910004, 0, 3, mk(32'h104, 32'hE5910004, 64'h10, 0, 4'b1100, 0, 1, 1));
    repeat (2) @(negedge clk);
    chk("held_req_count", 64'(req_rises - r0), 1);
    chk("held_ir_loads", 64'(ir_loads - l0), 1);

    // Branch EQ: fails with Z=0, passes with Z=1
    nzcv = 4'b0000;
    do_fetch(32'h108, 32'h0A000010, 0, 0, mk(32'h108, 32'h0A000010, 64'h4, 1, 4'b0000, 1, 0, 0));
    nzcv = 4'b0100;
    do_fetch(32'h10C, 32'h0A000010, 0, 0, mk(32'h10C, 32'h0A000010, 64'h4, 0, 4'b0000, 1, 0, 0));
    // Branch LT with N!=V passes; NV never passes
    nzcv = 4'b1000;
    do_fetch(32'h110, 32'hBA000000, 0, 0, mk(32'h110, 32'hBA000000, 64'h4, 0, 4'b0000, 1, 0, 0));
    do_fetch(32'h114, 32'hFA000000, 0, 0, mk(32'h114, 32'hFA000000, 64'h4, 1, 4'b0000, 1, 0, 0));
    nzcv = 4'b0000;
    // BX, SWP, STR1 and an undecodable word
    do_fetch(32'h118, 32'hE12FFF1E, 0, 0, mk(32'h118, 32'hE12FFF1E, 64'h2, 0, 4'b1001, 0, 1, 0));
    do_fetch(32'h11C, 32'hE1012093, 2, 0, mk(32'h11C, 32'hE1012093, 64'h100, 0, 4'b1000, 0, 1, 0));
    do_fetch(32'h120, 32'hE7810002, 0, 0, mk(32'h120, 32'hE7810002, 64'h80, 0, 4'b1100, 1, 1, 1));
    do_fetch(32'h124, 32'hE7000010, 0, 0, mk(32'h124, 32'hE7000010, 64'h0, TRAP, 4'b1000, 1, 1, 0));
`ifdef IFD_ILLEGAL_TRAP_EN
    chk("illegal", illegal, 1);
`endif

    // Timeout: no ack
    @(negedge clk);
    pc = 32'h200;
    write_ir = 1'b1;
    @(negedge clk);
    write_ir = 1'b0;
    cnt = 0;
    while (imem_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_len", 64'(cnt), 15);
    chk("timeout_bus_err", bus_err, 1);
    chk("timeout_ir_valid", ir_valid, 0);
    chk("timeout_command", command, 0);
    chk("timeout_ir_kept", ir, 32'hE7000010);
    // late ack after the abort is ignored
    imem_ack = 1'b1;
    imem_rdata = 32'h12345678;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_ir", ir, 32'hE7000010);

    do_fetch(32'h204, 32'hE3A01005, 0, 0, mk(32'h204, 32'hE3A01005, 64'h1, 0, 4'b1101, 1, 1, 1));
    chk("bus_err_sticky", bus_err, 1);

    // Reset in the middle of REQ
    @(negedge clk);
    pc = 32'h300;
    write_ir = 1'b1;
    @(negedge clk);
    chk("pre_rst_req", imem_req, 1);
    rst = 1'b1;
    write_ir = 1'b0;
    #1;
    chk("mid_rst_imem_req", imem_req, 0);
    chk("mid_rst_imem_addr", imem_addr, 0);
    chk("mid_rst_ir", ir, 0);
    chk("mid_rst_ir_valid", ir_valid, 0);
    chk("mid_rst_bus_err", bus_err, 0);
    chk("mid_rst_command", command, 0);
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hE3A01005;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("post_rst_ir_valid", ir_valid, 0);
    chk("post_rst_ir", ir, 0);
    chk("post_rst_req", imem_req, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_decode.md
Name: ifetch_decode

Overview:
- Instruction fetch and decode stage directly upstream of the multi-cycle control FSM.
- On a fetch request from the FSM (write_ir), issues an instruction-memory read at the current PC using a req/ack handshake.
- Latches the returned word into the IR and asserts ir_valid.
- Decodes the IR into the one-hot command vector, the field signals and the condition-fail flag that the FSM consumes.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles waiting for imem_ack before abort; 0 disables the timeout.
- ADDR_W, 32: PC / imem address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- write_ir  in  1  fetch request from FSM (level; rising edge starts a fetch)
- pc  in  ADDR_W  current program counter
- imem_req  out  1  memory read request
- imem_addr  out  ADDR_W  read address, held stable while imem_req=1
- imem_ack  in  1  read data valid, single-cycle pulse
- imem_rdata  in  32  instruction word
- ir_valid  out  1  IR holds a freshly fetched instruction (W_IR_valid to FSM)
- ir  out  32  instruction register
- command  out  64  one-hot decode, bit index = command code
- rm_imm_s  out  1  ir[25]
- rs_imm_s  out  2  {ir[25], ir[4]}
- shift_op  out  3  {ir[6:5], ir[4]}
- alu_op  out  4  ir[24:21]
- s_bit, p_bit, u_bit, w_bit  out  1 each  ir[20], ir[24], ir[23], ir[21]
- v_type  out  2  ir[6:5]
- nzcv  in  4  current flags {N,Z,C,V}
- cond_fail  out  1  condition ir[31:28] not satisfied (TTCC to FSM)
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset values: imem_req=0, imem_addr=0, ir=0, ir_valid=0, bus_err=0, state=IDLE, write_ir_q=0, timeout counter=0.
- Start event: write_ir & ~write_ir_q (write_ir_q registers write_ir each cycle). A held-high write_ir starts only one fetch.
- States:
  - IDLE --start--> REQ: imem_addr<=pc, imem_req<=1, ir_valid<=0.
  - REQ --imem_ack--> VALID: ir<=imem_rdata, imem_req<=0, ir_valid<=1. Minimum latency: start edge to ir_valid high is 2 cycles with ack on the first REQ cycle.
  - REQ, counter reaches TIMEOUT_CYCLES without ack --> IDLE: imem_req<=0, bus_err<=1, ir unchanged, ir_valid stays 0.
  - VALID --start--> REQ, same actions as from IDLE. ir_valid remains 1 until the next start.
- Start events seen while in REQ are ignored.
- imem_ack outside REQ is ignored.
- ack and timeout in the same cycle: ack wins.
- pc changes during REQ do not affect imem_addr.
- bus_err clears only on rst.
- Decode is combinational from ir; command bits 9..63 are always 0:
  - 1 BX: ir[27:4]==24'h12FFF1
  - 8 SWP: ir[27:23]==5'b00010 && ir[21:20]==0 && ir[11:4]==8'h09
  - 0 DP: ir[27:26]==00, and neither BX nor SWP
  - 2 B: ir[27:24]==1010
  - 3 BL: ir[27:24]==1011
  - 4 LDR0: ir[27:25]==010 && ir[20]
  - 5 LDR1: ir[27:25]==011 && !ir[4] && ir[20]
  - 6 STR0: same as LDR0 with !ir[20]
  - 7 STR1: same as LDR1 with !ir[20]
- Condition evaluation, ARM table (EQ..LE): AL(1110) passes; 1111 is treated as never and fails.
- When ir_valid=0, cond_fail is 0 and command is all-zero.

Optional Feature:
- Macro IFD_ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit), high while ir_valid=1 and command==0. Such words also drive cond_fail=1 so the FSM skips write-back.
- Undefined: no illegal port; an undecodable word yields command==0 and normal cond_fail.

Decomposition:
- Shared package: command index constants (DP=0 … SWP=8), condition-code constants, fetch state enum.
- One natural sub-module: ifd_cond_check (cond[3:0], nzcv -> pass), purely combinational.

Test Plan:
- rst, pc=0x100, write_ir 0->1, ack on 2nd REQ cycle with rdata=0xE3A01005 -> imem_addr=0x100, ir_valid=1, command[0]=1, alu_op=1101, rm_imm_s=1, cond_fail=0.
- write_ir held high 5 cycles, ack once -> exactly one imem_req assertion, one IR load.
- rdata=0x0A000010, nzcv=0000 -> command[2]=1, cond_fail=1; repeat with nzcv=0100 -> cond_fail=0.
- rdata=0xE12FFF1E -> command[1]=1 only; rdata=0xE1012093 -> command[8]=1 only; rdata=0xE5910004 -> command[4]=1, p_bit=1, u_bit=1.
- No ack for 15 cycles -> imem_req drops, bus_err=1, ir_valid=0. A subsequent fetch with ack succeeds and bus_err stays 1.
- rst asserted mid-REQ -> all outputs return to reset values immediately; a late ack after reset release is ignored.
